// File: rtl/router_fsm.sv
// Router control FSM: sequences header decode, payload/parity loads, full stalls and
// waits for the destination FIFO to drain. Outputs are Moore decodes of the state.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        StDecodeAddress    = 3'd0,
        StLoadFirstData    = 3'd1,
        StLoadData         = 3'd2,
        StFifoFullState    = 3'd3,
        StLoadAfterFull    = 3'd4,
        StLoadParity       = 3'd5,
        StCheckParityError = 3'd6,
        StWaitTillEmpty    = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    // Address 3 is invalid; padding bit 3 with zero keeps it from ever matching.
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       hdr_ok;

    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok    = pkt_valid && (data_in != 2'd3);

    // State and destination address registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StDecodeAddress;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and address capture; a soft reset of the selected FIFO wins over everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            StDecodeAddress: begin
                if (hdr_ok) begin
                    addr_d  = data_in;
                    state_d = empty_vec[data_in] ? StLoadFirstData : StWaitTillEmpty;
                end
            end
            StWaitTillEmpty: begin
                if (empty_vec[addr_q]) state_d = StLoadFirstData;
            end
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
                if (fifo_full)       state_d = StFifoFullState;
                else if (!pkt_valid) state_d = StLoadParity;
            end
            StFifoFullState: begin
                if (!fifo_full) state_d = StLoadAfterFull;
            end
            StLoadAfterFull: begin
                if (parity_done)        state_d = StDecodeAddress;
                else if (low_pkt_valid) state_d = StLoadParity;
                else                    state_d = StLoadData;
            end
            StLoadParity:       state_d = StCheckParityError;
            StCheckParityError: state_d = fifo_full ? StFifoFullState : StDecodeAddress;
            default:            state_d = StDecodeAddress;
        endcase
        if (soft_vec[addr_q]) state_d = StDecodeAddress;
    end

    // Moore output decodes.
    always_comb begin
        detect_add    = (state_q == StDecodeAddress);
        lfd_state     = (state_q == StLoadFirstData);
        ld_state      = (state_q == StLoadData);
        laf_state     = (state_q == StLoadAfterFull);
        full_state    = (state_q == StFifoFullState);
        rst_int_reg   = (state_q == StCheckParityError);
        write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                        (state_q == StLoadAfterFull);
        busy          = !((state_q == StDecodeAddress) || (state_q == StLoadData));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: drives packet scenarios and checks the full output decode
// against hand-computed per-state vectors.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;

    int n_checks = 0;
    int n_errors = 0;

    // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] ExpDec = 8'b1000_0000;
    localparam logic [7:0] ExpLfd = 8'b0100_0001;
    localparam logic [7:0] ExpLd  = 8'b0010_0010;
    localparam logic [7:0] ExpLaf = 8'b0001_0011;
    localparam logic [7:0] ExpFul = 8'b0000_1001;
    localparam logic [7:0] ExpLp  = 8'b0000_0011;
    localparam logic [7:0] ExpCpe = 8'b0000_0101;
    localparam logic [7:0] ExpWte = 8'b0000_0001;

    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                   write_enb_reg, busy};

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock, then compare outputs 1ns after the edge.
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clock);
        #1;
        check_eq(tag, outs, exp);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        step("reset0", ExpDec);
        step("reset1", ExpDec);
        resetn = 1'b1;

        // Header to FIFO 1, one payload byte, then parity.
        pkt_valid = 1'b1; data_in = 2'd1;
        step("f1_lfd", ExpLfd);
        data_in = 2'd0;
        step("f1_ld", ExpLd);
        pkt_valid = 1'b0;
        step("f1_lp", ExpLp);
        step("f1_cpe", ExpCpe);
        step("f1_dec", ExpDec);
        step("idle_dec", ExpDec);

        // 4-byte packet to FIFO 0.
        pkt_valid = 1'b1; data_in = 2'd0;
        step("f0_lfd", ExpLfd);
        for (int i = 0; i < 3; i++) step("f0_ld", ExpLd);
        pkt_valid = 1'b0;
        step("f0_lp", ExpLp);
        step("f0_cpe", ExpCpe);
        step("f0_dec", ExpDec);

        // Full stall for 3 cycles, release with low_pkt_valid.
        pkt_valid = 1'b1;
        step("full_lfd", ExpLfd);
        step("full_ld", ExpLd);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("full_hold", ExpFul);
        fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        step("full_laf", ExpLaf);
        step("laf_lp", ExpLp);
        low_pkt_valid = 1'b0;
        step("laf_cpe", ExpCpe);
        step("laf_dec", ExpDec);

        // LAF back to LD, then CPE with full -> FULL -> LAF with parity_done.
        pkt_valid = 1'b1;
        step("laf2_lfd", ExpLfd);
        fifo_full = 1'b1;
        step("laf2_ld", ExpLd);
        step("laf2_full", ExpFul);
        fifo_full = 1'b0;
        step("laf2_laf", ExpLaf);
        step("laf2_ld_back", ExpLd);
        pkt_valid = 1'b0;
        step("laf2_lp", ExpLp);
        fifo_full = 1'b1;
        step("laf2_cpe", ExpCpe);
        step("cpe_full", ExpFul);
        fifo_full = 1'b0; parity_done = 1'b1;
        step("pd_laf", ExpLaf);
        step("pd_dec", ExpDec);
        parity_done = 1'b0;

        // FIFO 2 not empty: wait, then drain after 5 cycles.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        step("wte_enter", ExpWte);
        pkt_valid = 1'b0; data_in = 2'd0;
        for (int i = 0; i < 4; i++) step("wte_hold", ExpWte);
        fifo_empty_2 = 1'b1;
        step("wte_lfd", ExpLfd);
        pkt_valid = 1'b1;
        step("abort_ld", ExpLd);
        resetn = 1'b0;
        step("abort_rst", ExpDec);
        step("abort_rst2", ExpDec);
        resetn = 1'b1; pkt_valid = 1'b0;
        step("abort_idle", ExpDec);

        // Soft resets while waiting on FIFO 2; addr must hold despite data_in changing.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        step("sr_wte", ExpWte);
        pkt_valid = 1'b0; data_in = 2'd0; soft_reset_0 = 1'b1;
        step("sr0_ignored", ExpWte);
        soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
        step("sr2_dec", ExpDec);
        soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;

        // Soft reset of the selected FIFO mid-payload.
        pkt_valid = 1'b1; data_in = 2'd1;
        step("sr1_lfd", ExpLfd);
        step("sr1_ld", ExpLd);
        soft_reset_1 = 1'b1;
        step("sr1_dec", ExpDec);
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        step("sr1_idle", ExpDec);

        // Invalid address 3 keeps the FSM in decode.
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) step("addr3_dec", ExpDec);
        pkt_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
